// File: rtl/serial_subtractor_4_bit_pkg.sv
// Shared width default and FSM state encoding for the bit-serial subtractor.
package serial_subtractor_4_bit_pkg;

   localparam int unsigned WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

endpackage : serial_subtractor_4_bit_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor_4_bit.sv
// Bit-serial A - B - Bin, LSB first, one bit per clock, registered result.
module serial_subtractor_4_bit
   import serial_subtractor_4_bit_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               br_q, br_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               bout_q, bout_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               fs_d, fs_bout;

   full_subtractor u_full_subtractor (
      .x    (a_q[0]),
      .y    (b_q[0]),
      .bin  (br_q),
      .d    (fs_d),
      .bout (fs_bout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         br_q    <= 1'b0;
         res_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         br_q    <= br_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next state; busy/done are registered from the next state so they track state_q exactly.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      br_d    = br_q;
      res_d   = res_q;
      diff_d  = diff_q;
      bout_d  = bout_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               br_d    = Bin;
               cnt_d   = '0;
               res_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = fs_bout;
            res_d = {fs_d, res_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               diff_d  = {fs_d, res_q[WIDTH-1:1]};
               bout_d  = fs_bout;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   assign D    = diff_q;
   assign Bout = bout_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule : serial_subtractor_4_bit

// File: doc/serial_subtractor_4_bit.md
SERIAL_SUBTRACTOR_4_BIT -- requirements
Module: serial_subtractor_4_bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and difference width in bits.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1: request a new subtraction; sampled only in IDLE or DONE.
REQ-005 The block SHALL have port A, input, WIDTH: minuend, captured when start is accepted.
REQ-006 The block SHALL have port B, input, WIDTH: subtrahend, captured when start is accepted.
REQ-007 The block SHALL have port Bin, input, 1: borrow-in, captured when start is accepted.
REQ-008 The block SHALL have port D, output, WIDTH: registered difference A-B-Bin mod 2^WIDTH.
REQ-009 The block SHALL have port Bout, output, 1: registered borrow-out; 1 iff A < B+Bin (unsigned).
REQ-010 The block SHALL have port busy, output, 1: high while bits are being processed.
REQ-011 The block SHALL have port done, output, 1: single-cycle pulse when D/Bout update.

Function
REQ-012 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-013 IDLE/DONE, start=1 at an edge: SHALL load A, B into shift registers and Bin into the borrow flop, clear the bit counter, and enter RUN.
REQ-014 IDLE, start=0: SHALL stay IDLE. DONE, start=0: SHALL go to IDLE.
REQ-015 RUN: each edge SHALL process one bit, LSB first: d=a^b^br; br_next=(~a&b)|(~(a^b)&br); shift operands right; shift d into the result register at the MSB end.
REQ-016 RUN: after the WIDTH-th bit edge, SHALL copy the result register to D and the final borrow to Bout, and enter DONE.
REQ-017 Latency: start high in cycle 0 -> busy high cycles 1..WIDTH -> done high in cycle WIDTH+1 with D/Bout valid from that cycle.
REQ-018 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); never both high.
REQ-019 start during RUN SHALL be ignored; operands SHALL not reload and timing SHALL not change.
REQ-020 D and Bout SHALL hold their last value through IDLE and through the following RUN, changing only at the REQ-016 edge.
REQ-021 start in DONE SHALL be accepted (back-to-back): busy high in the next cycle and done low there.
REQ-022 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide; no wrap-around within a single operation.

Reset
REQ-023 rst=1 at an edge SHALL force state IDLE, counter 0, borrow flop 0, shift registers 0, D=0, Bout=0, busy=0, done=0.
REQ-024 rst SHALL have priority over start in all states.
REQ-025 rst during RUN SHALL abort the operation: no done pulse, and D/Bout=0.

Structure
REQ-026 A shared package SHALL hold WIDTH default and the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10).
REQ-027 One sub-module, full_subtractor (inputs x, y, bin; outputs d, bout), SHALL implement the per-bit equation of REQ-015; it is purely combinational.
REQ-028 The FSM, counter, shift registers and output registers SHALL reside in serial_subtractor_4_bit.

Verification
REQ-029 A=9, B=3, Bin=0, start 1 cycle -> busy cycles 1-4, done in cycle 5, D=6, Bout=0.
REQ-030 A=3, B=9, Bin=0 -> D=4'b1010, Bout=1 in the done cycle.
REQ-031 A=0, B=0, Bin=1 -> D=4'hF, Bout=1; A=15, B=15, Bin=0 -> D=0, Bout=0.
REQ-032 start pulsed in cycle 2 of RUN with different operands -> ignored; result matches the first operands; done in cycle 5 only.
REQ-033 rst asserted in cycle 2 of RUN -> next cycle busy=0, done=0, D=0, Bout=0; no done pulse follows.
REQ-034 start held high across DONE (A=7, B=2 then A=2, B=7) -> done cycle 5 with D=5, Bout=0, busy cycle 6; second done cycle 10 with D=4'b1011, Bout=1.
